// File: rtl/uart_tx_fpga.sv
// UART transmitter: 11-bit frame (start, 8 data LSB first, parity, stop) per accepted request.
// Each bit is held for clksPerBit cycles of i_clkTx.
module uart_tx_fpga #(
   parameter int unsigned clksPerBit = 234,
   parameter bit          parityOdd  = 1'b0
) (
   input  logic       i_clkTx,
   input  logic       i_resetN,
   input  logic       i_txStart,
   input  logic [7:0] i_txBits,
   output logic       o_txBit,
   output logic       o_txBusy,
   output logic       o_txFinished
);

   localparam int unsigned CNT_W = (clksPerBit > 1) ? $clog2(clksPerBit) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(clksPerBit - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       shreg_q, shreg_d;
   logic             par_q, par_d;
   logic             tx_bit_d, busy_d, fin_d;
   logic             bit_end;

   assign bit_end = (cnt_q == CNT_LAST);

   // State and registered outputs
   always_ff @(posedge i_clkTx) begin
      if (!i_resetN) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         bit_q        <= '0;
         shreg_q      <= '0;
         par_q        <= 1'b0;
         o_txBit      <= 1'b1;
         o_txBusy     <= 1'b0;
         o_txFinished <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         bit_q        <= bit_d;
         shreg_q      <= shreg_d;
         par_q        <= par_d;
         o_txBit      <= tx_bit_d;
         o_txBusy     <= busy_d;
         o_txFinished <= fin_d;
      end
   end

   // Next-state and next-output logic; every transition happens on a bit boundary
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      bit_d    = bit_q;
      shreg_d  = shreg_q;
      par_d    = par_q;
      tx_bit_d = o_txBit;
      busy_d   = o_txBusy;
      fin_d    = 1'b0;

      if (state_q != IDLE) begin
         cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
      end

      case (state_q)
         IDLE: begin
            tx_bit_d = 1'b1;
            busy_d   = 1'b0;
            cnt_d    = '0;
            bit_d    = '0;
            if (i_txStart) begin
               shreg_d  = i_txBits;
               par_d    = parityOdd ? ~^i_txBits : ^i_txBits;
               state_d  = START;
               tx_bit_d = 1'b0;
               busy_d   = 1'b1;
            end
         end
         START: begin
            if (bit_end) begin
               state_d  = DATA;
               bit_d    = '0;
               tx_bit_d = shreg_q[0];
               shreg_d  = {1'b0, shreg_q[7:1]};
            end
         end
         DATA: begin
            if (bit_end) begin
               if (bit_q == 3'd7) begin
                  state_d  = PARITY;
                  tx_bit_d = par_q;
               end else begin
                  bit_d    = bit_q + 3'd1;
                  tx_bit_d = shreg_q[0];
                  shreg_d  = {1'b0, shreg_q[7:1]};
               end
            end
         end
         PARITY: begin
            if (bit_end) begin
               state_d  = STOP;
               tx_bit_d = 1'b1;
            end
         end
         STOP: begin
            if (bit_end) begin
               state_d  = IDLE;
               tx_bit_d = 1'b1;
               busy_d   = 1'b0;
               fin_d    = 1'b1;
            end
         end
         default: begin
            state_d  = IDLE;
            tx_bit_d = 1'b1;
            busy_d   = 1'b0;
         end
      endcase
   end

endmodule
